// File: rtl/motoro_uart_cmd_rx.sv
// motoro_uart_cmd_rx
// Receives 4-byte motor command packets over a 115200-baud UART line and
// drives the motor setpoint outputs.
//
// Packet format: A5, byte1, byte2, byte3
//   byte1[7]   start
//   byte1[6]   invOrStop
//   byte1[5:2] reserved, must be zero
//   byte1[1:0] freq[9:8]
//   byte2      freq[7:0]
//   byte3      byte1 ^ byte2
//
// Ports
//   clk50mhz     in   single 50 MHz clock
//   nReset       in   asynchronous active-low reset
//   rs232_rx     in   asynchronous UART line, idle high
//   m3start      out  motor run request
//   m3invOrStop  out  motor invert/stop request
//   m3freq       out  10-bit motor frequency setpoint
//   cmdValid     out  one-cycle pulse when a packet is accepted
//   frameErr     out  one-cycle pulse on a bad stop bit
//   pktErr       out  one-cycle pulse on checksum, reserved-bit or timeout error
//
// Port names do not follow the _i/_o suffix rule because the names are fixed
// by the surrounding motor-control system.

module motoro_uart_cmd_rx #(
  parameter int BIT_CYC     = 434,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FREQ_RST    = 100
) (
  input  logic       clk50mhz,
  input  logic       nReset,
  input  logic       rs232_rx,
  output logic       m3start,
  output logic       m3invOrStop,
  output logic [9:0] m3freq,
  output logic       cmdValid,
  output logic       frameErr,
  output logic       pktErr
);

  localparam int BitCntW = $clog2(BIT_CYC + 1);
  localparam int ToCntW  = $clog2(TIMEOUT_CYC + 1);
  localparam int HalfCyc = BIT_CYC / 2;

  localparam logic [BitCntW-1:0] BitLast  = BitCntW'(BIT_CYC - 1);
  localparam logic [BitCntW-1:0] HalfLast = BitCntW'(HalfCyc - 1);
  localparam logic [ToCntW-1:0]  ToLast   = ToCntW'(TIMEOUT_CYC - 1);
  localparam logic [9:0]         FreqRst  = 10'(FREQ_RST);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
  typedef enum logic [1:0] {PS_SYNC, PS_B1, PS_B2, PS_CK} psState_t;

  // Synchronizer and falling-edge detection
  logic       rxMeta_q;
  logic       rxSync_q;
  logic       rxPrev_q;
  logic [1:0] syncFill_q;
  logic       armed_q;
  logic       rxFall;

  // Byte receiver
  rxState_t         rxState_q;
  logic [BitCntW-1:0] bitCnt_q;
  logic [2:0]       bitIdx_q;
  logic [7:0]       shift_q;
  logic             byteValid_q;
  logic             frameErr_q;
  logic             rxFrameBad;

  // Packet parser
  psState_t         psState_q;
  logic [ToCntW-1:0] idleCnt_q;
  logic [7:0]       byte1_q;
  logic [7:0]       byte2_q;
  logic             m3start_q;
  logic             m3invOrStop_q;
  logic [9:0]       m3freq_q;
  logic             cmdValid_q;
  logic             pktErr_q;

  // syncFill_q marks when rxSync_q reflects the real line rather than its
  // reset value. The receiver only arms once it has seen a genuinely high
  // line, so a line held low across reset release never looks like a start bit.
  always_ff @(posedge clk50mhz or negedge nReset) begin
    if (!nReset) begin
      rxMeta_q   <= 1'b1;
      rxSync_q   <= 1'b1;
      rxPrev_q   <= 1'b1;
      syncFill_q <= 2'b00;
      armed_q    <= 1'b0;
    end else begin
      rxMeta_q   <= rs232_rx;
      rxSync_q   <= rxMeta_q;
      rxPrev_q   <= rxSync_q;
      syncFill_q <= {syncFill_q[0], 1'b1};
      armed_q    <= armed_q | (syncFill_q[1] & rxSync_q);
    end
  end

  assign rxFall = armed_q & rxPrev_q & ~rxSync_q;

  // A bad stop bit is flagged in the sampling cycle so the parser can drop
  // back to SYNC in the same cycle; this also keeps a simultaneous timeout
  // from producing pktErr alongside frameErr.
  assign rxFrameBad = (rxState_q == RX_STOP) && (bitCnt_q == BitLast) && !rxSync_q;

  // Byte receiver. The bit counter reloads to zero on every transition and
  // after every sample, so each sample lands exactly one bit period after the
  // previous one, starting from the middle of the start bit.
  always_ff @(posedge clk50mhz or negedge nReset) begin
    if (!nReset) begin
      rxState_q   <= RX_IDLE;
      bitCnt_q    <= '0;
      bitIdx_q    <= 3'd0;
      shift_q     <= 8'h00;
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      byteValid_q <= 1'b0;
      frameErr_q  <= 1'b0;
      case (rxState_q)
        RX_IDLE: begin
          bitCnt_q <= '0;
          bitIdx_q <= 3'd0;
          if (rxFall) begin
            rxState_q <= RX_START;
          end
        end
        RX_START: begin
          if (bitCnt_q == HalfLast) begin
            bitCnt_q  <= '0;
            rxState_q <= rxSync_q ? RX_IDLE : RX_DATA;
          end else begin
            bitCnt_q <= bitCnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (bitCnt_q == BitLast) begin
            bitCnt_q <= '0;
            shift_q  <= {rxSync_q, shift_q[7:1]};
            bitIdx_q <= bitIdx_q + 3'd1;
            if (bitIdx_q == 3'd7) begin
              rxState_q <= RX_STOP;
            end
          end else begin
            bitCnt_q <= bitCnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (bitCnt_q == BitLast) begin
            bitCnt_q  <= '0;
            rxState_q <= RX_IDLE;
            if (rxSync_q) begin
              byteValid_q <= 1'b1;
            end else begin
              frameErr_q <= 1'b1;
            end
          end else begin
            bitCnt_q <= bitCnt_q + 1'b1;
          end
        end
        default: begin
          rxState_q <= RX_IDLE;
          bitCnt_q  <= '0;
        end
      endcase
    end
  end

  // Packet parser. shift_q is stable while byteValid_q is high because the
  // receiver has just returned to IDLE. An A5 seen after SYNC is ordinary data.
  always_ff @(posedge clk50mhz or negedge nReset) begin
    if (!nReset) begin
      psState_q     <= PS_SYNC;
      idleCnt_q     <= '0;
      byte1_q       <= 8'h00;
      byte2_q       <= 8'h00;
      m3start_q     <= 1'b0;
      m3invOrStop_q <= 1'b0;
      m3freq_q      <= FreqRst;
      cmdValid_q    <= 1'b0;
      pktErr_q      <= 1'b0;
    end else begin
      cmdValid_q <= 1'b0;
      pktErr_q   <= 1'b0;
      if (rxFrameBad) begin
        psState_q <= PS_SYNC;
        idleCnt_q <= '0;
      end else if (byteValid_q) begin
        idleCnt_q <= '0;
        case (psState_q)
          PS_SYNC: begin
            if (shift_q == 8'hA5) begin
              psState_q <= PS_B1;
            end
          end
          PS_B1: begin
            byte1_q   <= shift_q;
            psState_q <= PS_B2;
          end
          PS_B2: begin
            byte2_q   <= shift_q;
            psState_q <= PS_CK;
          end
          PS_CK: begin
            psState_q <= PS_SYNC;
            if ((shift_q == (byte1_q ^ byte2_q)) && (byte1_q[5:2] == 4'b0000)) begin
              m3start_q     <= byte1_q[7];
              m3invOrStop_q <= byte1_q[6];
              m3freq_q      <= {byte1_q[1:0], byte2_q};
              cmdValid_q    <= 1'b1;
            end else begin
              pktErr_q <= 1'b1;
            end
          end
          default: psState_q <= PS_SYNC;
        endcase
      end else if (psState_q != PS_SYNC) begin
        if (idleCnt_q == ToLast) begin
          psState_q <= PS_SYNC;
          idleCnt_q <= '0;
          pktErr_q  <= 1'b1;
        end else begin
          idleCnt_q <= idleCnt_q + 1'b1;
        end
      end else begin
        idleCnt_q <= '0;
      end
    end
  end

  assign m3start     = m3start_q;
  assign m3invOrStop = m3invOrStop_q;
  assign m3freq      = m3freq_q;
  assign cmdValid    = cmdValid_q;
  assign frameErr    = frameErr_q;
  assign pktErr      = pktErr_q;

endmodule

// File: doc/motoro_uart_cmd_rx.md
MOTORO_UART_CMD_RX -- requirements
Module: motoro_uart_cmd_rx

Interface
REQ-001 SHALL have parameter BIT_CYC, default 434, meaning clk50mhz cycles per UART bit (115200 baud at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000, meaning the maximum idle gap between bytes within one packet (1 ms).
REQ-003 SHALL have parameter FREQ_RST, default 100, meaning the reset value of m3freq.
REQ-004 SHALL have port clk50mhz, input, 1 bit: the single clock.
REQ-005 SHALL have port nReset, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port rs232_rx, input, 1 bit: asynchronous UART line, idle high.
REQ-007 SHALL have port m3start, output, 1 bit: motor run request.
REQ-008 SHALL have port m3invOrStop, output, 1 bit: motor invert/stop request.
REQ-009 SHALL have port m3freq, output, 10 bits: motor frequency setpoint.
REQ-010 SHALL have port cmdValid, output, 1 bit: one-cycle pulse when a packet is accepted.
REQ-011 SHALL have port frameErr, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-012 SHALL have port pktErr, output, 1 bit: one-cycle pulse on a checksum, reserved-bit or timeout error.

Function
REQ-013 SHALL pass rs232_rx through a 2-flop synchronizer; all logic SHALL use only the synchronized value.
REQ-014 SHALL run a byte receiver FSM with states IDLE, START, DATA, STOP.
- IDLE -> START on a synchronized falling edge.
REQ-015 START SHALL re-sample the line at BIT_CYC/2 cycles.
- Line low: go to DATA.
- Line high: treat as a glitch and return to IDLE with no error.
REQ-016 DATA SHALL sample 8 bits, LSB first, each BIT_CYC cycles after the previous sample, then go to STOP.
REQ-017 STOP SHALL sample BIT_CYC cycles after the last data bit.
- Sample high: emit an internal byteValid pulse for one cycle.
- Sample low: pulse frameErr, discard the byte and reset the packet parser to SYNC.
- Both cases: return to IDLE.
REQ-018 SHALL run a packet parser FSM with states SYNC, B1, B2, CK, advancing only on byteValid.
- SYNC: byte 0xA5 -> B1; any other byte is ignored silently.
- B1: latch byte1 -> B2.
- B2: latch byte2 -> CK.
- CK: compare and return to SYNC.
REQ-019 Packet fields SHALL be defined as follows.
- byte1[7] = start.
- byte1[6] = invOrStop.
- byte1[5:2] = reserved, must be 0.
- byte1[1:0] = freq[9:8].
- byte2 = freq[7:0].
- byte3 = byte1 XOR byte2.
REQ-020 In CK, if byte3 matches and the reserved bits are 0, the block SHALL update m3start, m3invOrStop and m3freq and pulse cmdValid, all in the cycle after the byte3 byteValid.
REQ-021 In CK, on a checksum mismatch or non-zero reserved bits, the block SHALL leave the outputs unchanged and pulse pktErr.
REQ-022 In B1, B2 or CK, an inter-byte idle counter reaching TIMEOUT_CYC SHALL return the parser to SYNC and pulse pktErr.
- The counter SHALL be cleared by byteValid.
REQ-023 A 0xA5 received in B1, B2 or CK SHALL be treated as data, not as a resync.
REQ-024 The bit-period counter SHALL be wide enough for BIT_CYC and SHALL reload on every state transition; the divider SHALL never wrap mid-bit.
REQ-025 cmdValid, frameErr and pktErr SHALL never assert in the same cycle.
REQ-026 Outputs SHALL hold their values indefinitely between accepted packets.

Reset
REQ-027 While nReset is low, the block SHALL immediately set the following, independent of the clock:
- m3start = 0, m3invOrStop = 0, m3freq = FREQ_RST;
- cmdValid, frameErr and pktErr = 0;
- both FSMs to IDLE/SYNC;
- all counters to 0;
- synchronizer flops to 1.
REQ-028 A reset asserted mid-byte or mid-packet SHALL discard the partial data.
- After release, the block SHALL wait for a fresh falling edge.
- If the line is low at release, it SHALL wait for the line to go high before arming.

Verification
REQ-029 Send A5 81 2C AD at 115200 baud -> cmdValid pulses once; m3start=1, m3invOrStop=0, m3freq=0x12C (300).
REQ-030 Send A5 81 2C AC -> pktErr pulses once; outputs keep their reset values (0, 0, 100).
REQ-031 Send a byte with the stop bit held low, then A5 40 00 40 -> frameErr pulses, then cmdValid pulses; m3invOrStop=1, m3start=0, m3freq=0.
REQ-032 Send A5 81, idle 1.2 ms, then 2C AD -> pktErr pulses at the timeout; no cmdValid; the parser stays in SYNC, so the late bytes are ignored.
REQ-033 Apply a 2-cycle low glitch on rs232_rx, then send 55 A5 83 FF 7C -> no error pulses; cmdValid pulses; m3freq=0x3FF, m3start=1.
REQ-034 Assert nReset during byte2 of a valid packet, release it, then send A5 80 64 E4 -> outputs reset to (0, 0, 100); the following packet is accepted with m3freq=100, m3start=1.
